team_08_game_fsm: RTL and testbench

Top-level game-state controller for the dino runner. It sits directly downstream of team_08_collision_detector and consumes its collision_detect output. It drives the shared state_t bus back to the collision detector and to the dino, cactus and display blocks. It also owns the run score, the win condition, button edge detection and a one-cycle round-restart pulse.

---
 rtl/team_08_game_fsm.sv | 154 +++++++++++++++
 tb/tb_team_08_game_fsm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/team_08_game_fsm.sv
// -----------------------------------------------------------------------------
// team_08_game_fsm
// Top-level game-state controller for the dino runner. It takes
// collision_detect from team_08_collision_detector and drives the shared
// state_t bus back to the collision detector and to the dino, cactus and
// display blocks. The block also owns the run score, the win condition,
// button edge detection and the one-cycle round_start pulse.
//
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous reset, active low
//   button           in   raw start/jump button, asynchronous to clk
//   frame_tick       in   one-cycle pulse per display frame
//   collision_detect in   collision flag, sampled only while state==RUN
//   state            out  state_t: IDLE=0, RUN=1, OVER=2, WIN=3 (registered)
//   score            out  current run score (registered)
//   round_start      out  one-cycle pulse in the first RUN cycle (registered)
//   high_score       out  best final score since reset; present only when
//                         TEAM08_HIGH_SCORE_EN is defined
//
// Optional feature macro: TEAM08_HIGH_SCORE_EN
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a button press; score keeps the last round's value
// RUN   | round in progress; frame_ticks advance the score
// OVER  | collision ended the round; score frozen
// WIN   | score reached WIN_SCORE; score frozen at WIN_SCORE
// -----------------------------------------------------------------------------
module team_08_game_fsm #(
  parameter int SCORE_DIV = 30,
  parameter int WIN_SCORE = 99,
  parameter int SCORE_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button,
  input  logic               frame_tick,
  input  logic               collision_detect,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic               round_start
`ifdef TEAM08_HIGH_SCORE_EN
  ,
  output logic [SCORE_W-1:0] high_score
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2,
    WIN  = 2'd3
  } state_t;

  localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_TC = DIV_W'(SCORE_DIV - 1);
  localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);

  state_t             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [SCORE_W-1:0] score_q;
  logic               round_start_q;
  logic               sync1_q;
  logic               sync2_q;
  logic               edge_q;
  logic               btn_press;
  logic [SCORE_W-1:0] score_inc;

  // Two-flop synchronizer followed by a rising-edge detector flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // Built purely from flop outputs, so no input reaches an output without
  // passing through a register.
  assign btn_press = sync2_q & ~edge_q;
  assign score_inc = score_q + SCORE_W'(1);

`ifdef TEAM08_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      div_q         <= '0;
      score_q       <= '0;
      round_start_q <= 1'b0;
`ifdef TEAM08_HIGH_SCORE_EN
      high_score_q  <= '0;
`endif
    end else begin
      round_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_press) begin
            state_q       <= RUN;
            score_q       <= '0;
            div_q         <= '0;
            round_start_q <= 1'b1;
          end
        end
        RUN: begin
          // Collision outranks a score-completing frame_tick on the same edge.
          if (collision_detect) begin
            state_q <= OVER;
`ifdef TEAM08_HIGH_SCORE_EN
            if (score_q > high_score_q) high_score_q <= score_q;
`endif
          end else if (frame_tick) begin
            if (div_q == DIV_TC) begin
              div_q <= '0;
              if (score_inc == WIN_S) begin
                state_q <= WIN;
                score_q <= WIN_S;
`ifdef TEAM08_HIGH_SCORE_EN
                if (WIN_S > high_score_q) high_score_q <= WIN_S;
`endif
              end else begin
                score_q <= score_inc;
              end
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
        end
        OVER: begin
          if (btn_press) state_q <= IDLE;
        end
        WIN: begin
          if (btn_press) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state       = state_q;
  assign score       = score_q;
  assign round_start = round_start_q;
`ifdef TEAM08_HIGH_SCORE_EN
  assign high_score  = high_score_q;
`endif

endmodule

// File: tb/tb_team_08_game_fsm.sv
module tb_team_08_game_fsm;

  localparam int DIV = 3;
  localparam int WSC = 7;
  localparam int SW  = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          button = 1'b0;
  logic          frame_tick = 1'b0;
  logic          collision_detect = 1'b0;
  logic [1:0]    state;
  logic [SW-1:0] score;
  logic          round_start;
`ifdef TEAM08_HIGH_SCORE_EN
  logic [SW-1:0] high_score;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  team_08_game_fsm #(.SCORE_DIV(DIV), .WIN_SCORE(WSC), .SCORE_W(SW)) dut (
    .clk              (clk),
    .reset            (reset),
    .button           (button),
    .frame_tick       (frame_tick),
    .collision_detect (collision_detect),
    .state            (state),
    .score            (score),
    .round_start      (round_start)
`ifdef TEAM08_HIGH_SCORE_EN
    ,
    .high_score       (high_score)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the score is the count of RUN frame_ticks since the
  // round began divided by SCORE_DIV, capped at WIN_SCORE.
  int m_state = 0;
  int m_ticks = 0;
  int m_rs    = 0;
  int m_hs    = 0;
  int hist [3] = '{0, 0, 0};  // button sampled 1, 2, 3 edges ago

  function automatic int m_score(input int t);
    int s;
    s = t / DIV;
    return (s > WSC) ? WSC : s;
  endfunction

  always @(posedge clk or negedge reset) begin
    int ns, nt, nrs, nh, press;
    if (!reset) begin
      m_state <= 0;
      m_ticks <= 0;
      m_rs    <= 0;
      m_hs    <= 0;
      hist    <= '{0, 0, 0};
    end else begin
      ns = m_state; nt = m_ticks; nrs = 0; nh = m_hs;
      press = (hist[1] == 1 && hist[2] == 0) ? 1 : 0;
      case (m_state)
        0: if (press == 1) begin ns = 1; nt = 0; nrs = 1; end
        1: begin
          if (collision_detect) begin
            ns = 2;
            if (m_score(nt) > nh) nh = m_score(nt);
          end else if (frame_tick) begin
            nt = nt + 1;
            if (nt / DIV >= WSC) begin
              ns = 3;
              if (WSC > nh) nh = WSC;
            end
          end
        end
        default: if (press == 1) ns = 0;
      endcase
      m_state <= ns;
      m_ticks <= nt;
      m_rs    <= nrs;
      m_hs    <= nh;
      hist    <= '{int'(button), hist[0], hist[1]};
    end
  end

  always @(negedge clk) begin
    chk("state", int'(state), m_state);
    chk("score", int'(score), m_score(m_ticks));
    chk("round_start", int'(round_start), m_rs);
`ifdef TEAM08_HIGH_SCORE_EN
    chk("high_score", int'(high_score), m_hs);
`endif
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    button = 1'b1; step(4);
    button = 1'b0; step(2);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1; step(1);
      frame_tick = 1'b0; step(1);
    end
  endtask

  task automatic collide();
    collision_detect = 1'b1; step(1);
    collision_detect = 1'b0; step(1);
  endtask

  initial begin
    step(2);
    reset = 1'b1;
    step(2);
    chk("lit_reset_state", int'(state), 0);
    chk("lit_reset_score", int'(score), 0);

    // Start: button held 10 cycles, RUN appears on the 3rd edge after the rise.
    button = 1'b1;
    step(2);
    chk("lit_start_not_yet", int'(state), 0);
    step(1);
    chk("lit_start_run", int'(state), 1);
    chk("lit_start_rs_hi", int'(round_start), 1);
    chk("lit_start_score", int'(score), 0);
    step(1);
    chk("lit_start_rs_lo", int'(round_start), 0);
    step(6);
    button = 1'b0;
    step(2);
    chk("lit_start_held", int'(state), 1);

    // Scoring and ignored presses in RUN.
    ticks(9);
    chk("lit_score3", int'(score), 3);
    press();
    chk("lit_press_in_run", int'(state), 1);

    // Collision at score 4.
    ticks(3);
    chk("lit_score4", int'(score), 4);
    collide();
    chk("lit_over", int'(state), 2);
    chk("lit_over_score", int'(score), 4);
    press();
    chk("lit_idle", int'(state), 0);
    chk("lit_idle_score", int'(score), 4);
    press();
    chk("lit_restart_score", int'(score), 0);

    // Win: score 6 with divider at terminal count, then a lone tick.
    ticks(20);
    frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(1);
    chk("lit_win", int'(state), 3);
    chk("lit_win_score", int'(score), WSC);
    press(); press();
    ticks(20);
    frame_tick = 1'b1; collision_detect = 1'b1; step(1);
    frame_tick = 1'b0; collision_detect = 1'b0; step(1);
    chk("lit_prio_over", int'(state), 2);
    chk("lit_prio_score", int'(score), 6);

    // Asynchronous reset mid-RUN with score 5.
    press(); press();
    ticks(15);
    #2;
    reset = 1'b0;
    #1;
    chk("lit_async_state", int'(state), 0);
    chk("lit_async_score", int'(score), 0);
    chk("lit_async_rs", int'(round_start), 0);
    step(3);
    reset = 1'b1;
    step(3);
    chk("lit_after_release", int'(state), 0);

`ifdef TEAM08_HIGH_SCORE_EN
    press(); ticks(18); collide(); press();
    press(); ticks(9);  collide(); press();
    chk("lit_high_score", int'(high_score), 6);
    reset = 1'b0; step(1); reset = 1'b1; step(1);
    chk("lit_high_score_rst", int'(high_score), 0);
`endif

    // Randomised phase against the model.
    for (int i = 0; i < 4000; i++) begin
      frame_tick       = 1'($urandom_range(0, 1));
      collision_detect = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 11) == 0) button = ~button;
      if (i == 2000) reset = 1'b0;
      if (i == 2003) reset = 1'b1;
      step(1);
    end
    frame_tick = 1'b0; collision_detect = 1'b0; button = 1'b0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
